md_ctrl: RTL and testbench

Multiply/divide sequencer for the E stage of the pipelined MIPS core. It accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo requests from E and runs each arithmetic operation over a fixed multi-cycle latency. HI/LO are updated only when that latency expires. It also generates the D-stage stall that keeps HI/LO-class instructions out of E while an operation is issuing or in flight.

---
 rtl/md_pkg.sv | 28 ++
 rtl/md_if.sv | 23 ++
 rtl/md_arith.sv | 71 +++++++
 rtl/md_ctrl.sv | 127 ++++++++++++
 tb/tb_md_ctrl.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer: op codes, FSM states
// and default latencies.
package md_pkg;

   localparam logic [3:0] MD_NONE  = 4'd0;
   localparam logic [3:0] MD_MULT  = 4'd1;
   localparam logic [3:0] MD_MULTU = 4'd2;
   localparam logic [3:0] MD_DIV   = 4'd3;
   localparam logic [3:0] MD_DIVU  = 4'd4;
   localparam logic [3:0] MD_MFHI  = 4'd5;
   localparam logic [3:0] MD_MFLO  = 4'd6;
   localparam logic [3:0] MD_MTHI  = 4'd7;
   localparam logic [3:0] MD_MTLO  = 4'd8;

   localparam int MULT_LAT_DEF = 5;
   localparam int DIV_LAT_DEF  = 10;

   typedef enum logic {
      IDLE,
      RUN
   } md_state_t;

   // True for the four ops that occupy the sequencer for a multi-cycle latency
   function automatic logic isArith(input logic [3:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/md_if.sv
// E-stage request / status bundle between the pipeline and the HI/LO sequencer.
interface md_if;

   logic [3:0]  E_MDOp;
   logic [31:0] E_rsData;
   logic [31:0] E_rtData;
   logic        D_isMD;
   logic [31:0] HILOOut;
   logic        busy;
   logic        stall;
   logic        err;

   modport master (
      output E_MDOp, E_rsData, E_rtData, D_isMD,
      input  HILOOut, busy, stall, err
   );

   modport slave (
      input  E_MDOp, E_rsData, E_rtData, D_isMD,
      output HILOOut, busy, stall, err
   );

endinterface

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath; produces the full HI/LO result for
// one op so the sequencer only has to hold it until the latency expires.
module md_arith
   import md_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [31:0] rs,
   input  logic [31:0] rt,
   output logic [31:0] res_hi,
   output logic [31:0] res_lo,
   output logic        div0
);

   logic signed [63:0] sProd;
   logic        [63:0] uProd;
   logic signed [31:0] sQuo;
   logic signed [31:0] sRem;
   logic        [31:0] uQuo;
   logic        [31:0] uRem;

   // Division is only evaluated when it is well defined; the signed overflow
   // case is pinned explicitly rather than left to the divider.
   always_comb begin
      sProd  = '0;
      uProd  = '0;
      sQuo   = '0;
      sRem   = '0;
      uQuo   = '0;
      uRem   = '0;
      res_hi = '0;
      res_lo = '0;
      div0   = 1'b0;
      case (op)
         MD_MULT: begin
            sProd  = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
            res_hi = sProd[63:32];
            res_lo = sProd[31:0];
         end
         MD_MULTU: begin
            uProd  = {32'd0, rs} * {32'd0, rt};
            res_hi = uProd[63:32];
            res_lo = uProd[31:0];
         end
         MD_DIV: begin
            if (rt == 32'd0) begin
               div0 = 1'b1;
            end else if (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) begin
               res_lo = 32'h8000_0000;
               res_hi = 32'd0;
            end else begin
               sQuo   = $signed(rs) / $signed(rt);
               sRem   = $signed(rs) % $signed(rt);
               res_lo = sQuo;
               res_hi = sRem;
            end
         end
         MD_DIVU: begin
            if (rt == 32'd0) begin
               div0 = 1'b1;
            end else begin
               uQuo   = rs / rt;
               uRem   = rs % rt;
               res_lo = uQuo;
               res_hi = uRem;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/md_ctrl.sv
// HI/LO sequencer: runs mult/div over a fixed latency, commits HI/LO when it
// expires, and stalls D-stage HI/LO-class instructions meanwhile.
module md_ctrl
   import md_pkg::*;
#(
   parameter int MULT_LAT = MULT_LAT_DEF,
   parameter int DIV_LAT  = DIV_LAT_DEF
) (
   input logic clk,
   input logic reset,
   md_if.slave bus
);

   localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
   localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);

   md_state_t   state;
   md_state_t   stateNext;
   logic [3:0]  cnt;
   logic [3:0]  cntNext;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] pend_hi;
   logic [31:0] pend_lo;
   logic        pend_wr;
   logic        errReg;
   logic        busy;
   logic        start;
   logic        commit;
   logic [31:0] resHi;
   logic [31:0] resLo;
   logic        div0;

   assign busy   = (cnt != 4'd0);
   assign start  = !busy && isArith(bus.E_MDOp);
   assign commit = (state == RUN) && (cnt == 4'd1);

   md_arith u_arith (
      .op     (bus.E_MDOp),
      .rs     (bus.E_rsData),
      .rt     (bus.E_rtData),
      .res_hi (resHi),
      .res_lo (resLo),
      .div0   (div0)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= stateNext;
         cnt   <= cntNext;
      end
   end

   always_comb begin
      stateNext = state;
      cntNext   = cnt;
      case (state)
         IDLE: begin
            if (start) begin
               stateNext = RUN;
               cntNext   = (bus.E_MDOp == MD_DIV || bus.E_MDOp == MD_DIVU) ? DIV_CNT : MULT_CNT;
            end
         end
         RUN: begin
            if (cnt == 4'd1) begin
               stateNext = IDLE;
               cntNext   = 4'd0;
            end else begin
               cntNext = cnt - 4'd1;
            end
         end
         default: begin
            stateNext = IDLE;
            cntNext   = 4'd0;
         end
      endcase
   end

   // Result is captured at issue so later operand changes in E cannot disturb it;
   // a divide by zero still runs the full latency but never writes HI/LO.
   always_ff @(posedge clk) begin
      if (reset) begin
         hi      <= 32'd0;
         lo      <= 32'd0;
         pend_hi <= 32'd0;
         pend_lo <= 32'd0;
         pend_wr <= 1'b0;
         errReg  <= 1'b0;
      end else begin
         if (start) begin
            pend_hi <= resHi;
            pend_lo <= resLo;
            pend_wr <= !div0;
         end
         if (commit && pend_wr) begin
            hi <= pend_hi;
            lo <= pend_lo;
         end
         if (!busy && bus.E_MDOp == MD_MTHI) begin
            hi <= bus.E_rsData;
         end
         if (!busy && bus.E_MDOp == MD_MTLO) begin
            lo <= bus.E_rsData;
         end
         if (busy && bus.E_MDOp != MD_NONE) begin
            errReg <= 1'b1;
         end
      end
   end

   always_comb begin
      bus.HILOOut = 32'd0;
      case (bus.E_MDOp)
         MD_MFHI: bus.HILOOut = hi;
         MD_MFLO: bus.HILOOut = lo;
         default: ;
      endcase
   end

   assign bus.busy  = busy;
   assign bus.stall = bus.D_isMD && (busy || start);
   assign bus.err   = errReg;

endmodule

// File: tb/tb_md_ctrl.sv
// Self-checking bench for md_ctrl: table of arithmetic ops with hand-computed
// HI/LO, plus directed sequences for back-to-back, mtlo, mid-op reset and err.
module tb_md_ctrl;
   import md_pkg::*;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] rs;
      logic [31:0] rt;
      int          lat;
      logic [31:0] expHi;
      logic [31:0] expLo;
      string       name;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   int   testsRun    = 0;
   int   testsFailed = 0;
   vec_t vecs [9];

   always #5 clk = ~clk;

   md_if bus ();

   md_ctrl #(
      .MULT_LAT (5),
      .DIV_LAT  (10)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt, input logic dIsMd);
      bus.E_MDOp   = op;
      bus.E_rsData = rs;
      bus.E_rtData = rt;
      bus.D_isMD   = dIsMd;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reads HI then LO over two cycles; entered and left just after a rising edge
   task automatic readHiLo(input string name, input logic [31:0] expHi, input logic [31:0] expLo);
      applyStimulus(MD_MFHI, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      checkOutput({name, " HI"}, bus.HILOOut, expHi);
      tick();
      applyStimulus(MD_MFLO, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      checkOutput({name, " LO"}, bus.HILOOut, expLo);
      tick();
      applyStimulus(MD_NONE, 32'd0, 32'd0, 1'b0);
   endtask

   // Issues one op with D_isMD held high; returns at the negedge of cycle T0+lat
   task automatic runArith(input string name, input logic [3:0] op, input logic [31:0] rs,
                           input logic [31:0] rt, input int lat);
      applyStimulus(op, rs, rt, 1'b1);
      #1;
      checkOutput({name, " stall@start"}, 32'(bus.stall), 32'd1);
      checkOutput({name, " busy@start"}, 32'(bus.busy), 32'd0);
      tick();
      applyStimulus(MD_NONE, 32'd0, 32'd0, 1'b1);
      for (int k = 0; k < lat; k++) begin
         @(negedge clk);
         checkOutput($sformatf("%s busy[%0d]", name, k), 32'(bus.busy), 32'd1);
         checkOutput($sformatf("%s stall[%0d]", name, k), 32'(bus.stall), 32'd1);
         tick();
      end
      @(negedge clk);
      checkOutput({name, " busy@end"}, 32'(bus.busy), 32'd0);
      checkOutput({name, " stall@end"}, 32'(bus.stall), 32'd0);
   endtask

   initial begin
      vecs[0] = '{MD_MULT,  32'hFFFF_FFFE, 32'h0000_0003,  5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult -2*3"};
      vecs[1] = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  5, 32'hFFFF_FFFE, 32'h0000_0001, "multu max*max"};
      vecs[2] = '{MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div -7/2"};
      vecs[3] = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000, "div min/-1"};
      vecs[4] = '{MD_DIVU,  32'h0000_0007, 32'h0000_0000, 10, 32'h0000_0000, 32'h8000_0000, "divu 7/0"};
      vecs[5] = '{MD_DIVU,  32'h0000_0064, 32'h0000_0007, 10, 32'h0000_0002, 32'h0000_000E, "divu 100/7"};
      vecs[6] = '{MD_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD, "div 7/-2"};
      vecs[7] = '{MD_MULT,  32'h0001_0000, 32'h0001_0000,  5, 32'h0000_0001, 32'h0000_0000, "mult 2^16*2^16"};
      vecs[8] = '{MD_DIV,   32'h0000_0005, 32'h0000_0000, 10, 32'h0000_0001, 32'h0000_0000, "div 5/0"};

      reset = 1'b1;
      applyStimulus(MD_NONE, 32'd0, 32'd0, 1'b0);
      tick();
      tick();
      reset = 1'b0;
      applyStimulus(MD_NONE, 32'd0, 32'd0, 1'b1);
      @(negedge clk);
      checkOutput("reset busy", 32'(bus.busy), 32'd0);
      checkOutput("reset stall", 32'(bus.stall), 32'd0);
      checkOutput("reset err", 32'(bus.err), 32'd0);
      tick();
      readHiLo("reset", 32'd0, 32'd0);

      for (int i = 0; i < 9; i++) begin
         runArith(vecs[i].name, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].lat);
         tick();
         readHiLo(vecs[i].name, vecs[i].expHi, vecs[i].expLo);
      end

      // mtlo issued in the first free cycle after a mult lands on the next cycle
      runArith("mult 2*3", MD_MULT, 32'd2, 32'd3, 5);
      applyStimulus(MD_MTLO, 32'h0000_1234, 32'd0, 1'b0);
      tick();
      readHiLo("mtlo after mult", 32'h0000_0000, 32'h0000_1234);

      // back-to-back: the divu starts in the very cycle the mult finishes
      runArith("b2b mult 5*5", MD_MULT, 32'd5, 32'd5, 5);
      runArith("b2b divu 100/7", MD_DIVU, 32'd100, 32'd7, 10);
      tick();
      readHiLo("b2b", 32'h0000_0002, 32'h0000_000E);

      // reset on edge T0+3 of a div aborts without a later commit
      applyStimulus(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
      tick();
      applyStimulus(MD_NONE, 32'd0, 32'd0, 1'b0);
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkOutput("midreset busy", 32'(bus.busy), 32'd0);
      for (int k = 0; k < 10; k++) tick();
      readHiLo("midreset", 32'd0, 32'd0);

      // mthi while busy is dropped and latches a sticky err
      applyStimulus(MD_MTHI, 32'h0000_0055, 32'd0, 1'b0);
      tick();
      applyStimulus(MD_MULT, 32'd2, 32'd3, 1'b0);
      tick();
      applyStimulus(MD_MTHI, 32'h0000_DEAD, 32'd0, 1'b0);
      #1;
      checkOutput("err before", 32'(bus.err), 32'd0);
      tick();
      applyStimulus(MD_NONE, 32'd0, 32'd0, 1'b0);
      checkOutput("err set", 32'(bus.err), 32'd1);
      for (int k = 0; k < 10; k++) tick();
      checkOutput("err sticky", 32'(bus.err), 32'd1);
      readHiLo("mthi ignored", 32'h0000_0000, 32'h0000_0006);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      checkOutput("err cleared", 32'(bus.err), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
